// File: rtl/program_loader.sv
// Boot-time loader: receives a length-prefixed big-endian byte image, writes it word by
// word into instruction memory, then releases the MIPS datapath from reset.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [16:0] MaxWordsL = 17'(MAX_WORDS);

  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, WRITE, RUN, ERR} state_t;

  state_t                state_q, state_d;
  logic [7:0]            countHi_q, countHi_d;
  logic [15:0]           wordCount_q, wordCount_d;
  logic [ADDR_WIDTH-1:0] wordIdx_q, wordIdx_d;
  logic [1:0]            byteIdx_q, byteIdx_d;
  logic [23:0]           shift_q, shift_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpuReset_q, cpuReset_d;

  logic                  accept;
  logic [15:0]           rxCount;
  logic [ADDR_WIDTH:0]   wordNext;

  assign rx_ready   = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == DATA);
  assign imem_we    = (state_q == WRITE);
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERR);
  assign cpu_reset  = cpuReset_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  always_comb begin
    state_d     = state_q;
    countHi_d   = countHi_q;
    wordCount_d = wordCount_q;
    wordIdx_d   = wordIdx_q;
    byteIdx_d   = byteIdx_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    accept      = rx_valid && rx_ready;
    rxCount     = {countHi_q, rx_data};
    wordNext    = {1'b0, wordIdx_q} + 1'b1;

    case (state_q)
      CNT_HI: begin
        if (accept) begin
          countHi_d = rx_data;
          state_d   = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          wordCount_d = rxCount;
          byteIdx_d   = '0;
          wordIdx_d   = '0;
          if (rxCount == 16'd0) begin
            state_d = RUN;
          end else if ({1'b0, rxCount} > MaxWordsL) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          shift_d   = {shift_q[15:0], rx_data};
          byteIdx_d = byteIdx_q + 2'd1;
          // The fourth byte completes the word; latch it together with its address.
          if (byteIdx_q == 2'd3) begin
            wdata_d = {shift_q, rx_data};
            addr_d  = 32'({wordIdx_q, 2'b00});
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (16'(wordNext) == wordCount_q) begin
          state_d = RUN;
        end else begin
          wordIdx_d = wordIdx_q + 1'b1;
          state_d   = DATA;
        end
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = CNT_HI;
    endcase

    // Registered so the datapath sees a clean edge one cycle after the last write.
    cpuReset_d = (state_d != RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CNT_HI;
      countHi_q   <= '0;
      wordCount_q <= '0;
      wordIdx_q   <= '0;
      byteIdx_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpuReset_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      countHi_q   <= countHi_d;
      wordCount_q <= wordCount_d;
      wordIdx_q   <= wordIdx_d;
      byteIdx_q   <= byteIdx_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpuReset_q  <= cpuReset_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a byte-count model of the loader is checked
// against the DUT every cycle, and captured memory writes are checked per test.
module tb_program_loader;

  localparam int MAX_WORDS = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: counts accepted bytes since reset; words complete every 4 bytes after the 2 count bytes.
  int          mAcc = 0;
  int          mN = 0;
  int          mWritten = 0;
  int          mFinal = 0;
  bit          mWriteNow = 1'b0;
  logic [7:0]  mHi = '0;
  logic [31:0] mWord = '0;
  logic [31:0] mAddr = '0;
  logic [31:0] mData = '0;

  always @(posedge clock) begin
    if (reset) begin
      mAcc <= 0; mN <= 0; mWritten <= 0; mFinal <= 0; mWriteNow <= 1'b0;
      mHi <= '0; mWord <= '0; mAddr <= '0; mData <= '0;
    end else if (mWriteNow) begin
      mWriteNow <= 1'b0;
      mWritten  <= mWritten + 1;
      if (mWritten + 1 == mN) mFinal <= 1;
    end else if (rx_valid && mFinal == 0) begin
      mAcc  <= mAcc + 1;
      mWord <= {mWord[23:0], rx_data};
      if (mAcc + 1 == 1) begin
        mHi <= rx_data;
      end else if (mAcc + 1 == 2) begin
        mN <= int'({mHi, rx_data});
        if (int'({mHi, rx_data}) == 0) mFinal <= 1;
        else if (int'({mHi, rx_data}) > MAX_WORDS) mFinal <= 2;
      end else if ((mAcc + 1 - 2) % 4 == 0) begin
        mWriteNow <= 1'b1;
        mData     <= {mWord[23:0], rx_data};
        mAddr     <= 32'(((mAcc + 1 - 2) / 4 - 1) * 4);
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("rx_ready",   32'(rx_ready),  32'(mFinal == 0 && !mWriteNow));
      checkOutput("imem_we",    32'(imem_we),   32'(mWriteNow));
      checkOutput("cpu_reset",  32'(cpu_reset), 32'(mFinal != 1));
      checkOutput("done",       32'(done),      32'(mFinal == 1));
      checkOutput("error",      32'(error),     32'(mFinal == 2));
      checkOutput("imem_addr",  imem_addr,      mAddr);
      checkOutput("imem_wdata", imem_wdata,     mData);
    end
  end

  // Instruction memory as seen through the write port.
  logic [31:0] dutMem [MAX_WORDS];
  int          writeCount = 0;
  logic [31:0] lastAddr = '0;
  logic [31:0] lastData = '0;

  always @(posedge clock) begin
    if (imem_we === 1'b1) begin
      dutMem[imem_addr[9:2]] <= imem_wdata;
      writeCount <= writeCount + 1;
      lastAddr   <= imem_addr;
      lastData   <= imem_wdata;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Offers each byte until accepted, with rx_valid high on validPct percent of cycles.
  task automatic applyStimulus(input logic [7:0] q[$], input int validPct);
    foreach (q[i]) begin
      bit taken = 1'b0;
      int waited = 0;
      while (!taken) begin
        @(negedge clock);
        rx_valid = ($urandom_range(99) < validPct);
        rx_data  = rx_valid ? q[i] : 8'($urandom);
        taken    = rx_valid && rx_ready;
        waited++;
        if (!taken && waited > 200) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL byte_accept_timeout got=not_accepted expected=accepted byte %0d", i);
          rx_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  logic [7:0] s[$];
  logic [31:0] img[$];
  int base;

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    applyReset();
    checkEn = 1'b1;
    checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("reset_rx_ready",  32'(rx_ready),  32'd1);
    checkOutput("reset_done",      32'(done),      32'd0);
    checkOutput("reset_addr",      imem_addr,      32'd0);

    // Two-word image with continuous valid
    base = writeCount;
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    applyStimulus(s, 100);
    waitCycles(3);
    checkOutput("t1_writes", 32'(writeCount - base), 32'd2);
    checkOutput("t1_mem0",   dutMem[0], 32'h20080005);
    checkOutput("t1_mem1",   dutMem[1], 32'h01095020);
    checkOutput("t1_done",   32'(done), 32'd1);

    // Empty image
    applyReset();
    base = writeCount;
    s = '{8'h00, 8'h00};
    applyStimulus(s, 100);
    waitCycles(2);
    checkOutput("t2_writes",   32'(writeCount - base), 32'd0);
    checkOutput("t2_done",     32'(done), 32'd1);
    checkOutput("t2_rx_ready", 32'(rx_ready), 32'd0);

    // Oversized count; further bytes must be ignored
    applyReset();
    base = writeCount;
    s = '{8'h01, 8'h01};
    applyStimulus(s, 100);
    repeat (10) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data = 8'($urandom);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    checkOutput("t3_error",     32'(error), 32'd1);
    checkOutput("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("t3_writes",    32'(writeCount - base), 32'd0);

    // Single word with a gapped valid pattern
    applyReset();
    base = writeCount;
    s = '{8'h00, 8'h01};
    applyStimulus(s, 100);
    begin
      logic [7:0] bytes4 [4];
      bit pat [7];
      int k;
      bytes4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      k = 0;
      foreach (pat[c]) begin
        @(negedge clock);
        rx_valid = pat[c] && (k < 4);
        rx_data  = (k < 4) ? bytes4[k] : 8'h00;
        if (rx_valid && rx_ready) k++;
      end
      @(negedge clock);
      rx_valid = 1'b0;
    end
    waitCycles(3);
    checkOutput("t4_writes", 32'(writeCount - base), 32'd1);
    checkOutput("t4_mem0",   dutMem[0], 32'hDEADBEEF);
    checkOutput("t4_addr",   lastAddr, 32'h0);

    // Reset in the middle of word 1, then a fresh one-word image
    applyReset();
    base = writeCount;
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    applyStimulus(s, 100);
    applyReset();
    checkOutput("t5_writes_before", 32'(writeCount - base), 32'd1);
    checkOutput("t5_mem0_kept",     dutMem[0], 32'h11223344);
    checkOutput("t5_addr_reset",    imem_addr, 32'd0);
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(s, 100);
    waitCycles(3);
    checkOutput("t5_writes_after", 32'(writeCount - base), 32'd2);
    checkOutput("t5_mem0",         dutMem[0], 32'hAABBCCDD);

    // Full 256-word image, word i = i
    applyReset();
    base = writeCount;
    s = '{8'h01, 8'h00};
    for (int i = 0; i < MAX_WORDS; i++) begin
      s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'(i));
    end
    applyStimulus(s, 100);
    waitCycles(3);
    checkOutput("t6_writes",    32'(writeCount - base), 32'd256);
    checkOutput("t6_last_addr", lastAddr, 32'h3FC);
    checkOutput("t6_last_data", lastData, 32'hFF);
    checkOutput("t6_done",      32'(done), 32'd1);

    // Randomized images, random gaps, occasional oversize counts and mid-stream resets
    for (int t = 0; t < 20; t++) begin
      int n;
      int mode;
      int cut;
      applyReset();
      base = writeCount;
      mode = $urandom_range(9);
      n = (mode == 0) ? $urandom_range(300, 257) : $urandom_range(12, 1);
      s = {};
      img = {};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int w = 0; w < n && n <= MAX_WORDS; w++) begin
        logic [31:0] word;
        word = $urandom;
        img.push_back(word);
        s.push_back(word[31:24]); s.push_back(word[23:16]);
        s.push_back(word[15:8]);  s.push_back(word[7:0]);
      end
      if (mode == 1 && s.size() > 3) begin
        cut = $urandom_range(s.size() - 1, 3);
        while (s.size() > cut) s.pop_back();
        applyStimulus(s, $urandom_range(100, 30));
        applyReset();
      end else begin
        applyStimulus(s, $urandom_range(100, 30));
        waitCycles(3);
        if (n > MAX_WORDS) begin
          checkOutput("rand_error_writes", 32'(writeCount - base), 32'd0);
        end else begin
          checkOutput("rand_writes", 32'(writeCount - base), 32'(n));
          foreach (img[w]) checkOutput("rand_mem", dutMem[w], img[w]);
        end
      end
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader sitting directly upstream of the single-cycle MIPS datapath's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory from byte address 0.
- Holds the datapath in reset (cpu_reset) until the whole image is written, then releases it so the PC starts fetching at 0.

Parameters:
ADDR_WIDTH, 8, word-address bits of instruction memory; capacity MAX_WORDS = 2**ADDR_WIDTH.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word
imem_addr  output  32  byte address of write (word_index*4, bits [1:0] always 0)
imem_wdata  output  32  assembled instruction word
cpu_reset  output  1  reset to datapath; 1 while loading, 0 once image is complete
done  output  1  image loaded, CPU running
error  output  1  word count exceeded MAX_WORDS

Behaviour:
- Reset is synchronous and active-high: it takes effect only at a rising clock edge while reset is asserted.
- Byte accepted at a rising edge iff rx_valid && rx_ready. rx_data ignored otherwise. No timeout; rx_valid gaps of any length are legal.
- Reset values: state CNT_HI, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, error 0. rx_ready is 1 in the first cycle after reset. Internal word count, word index and byte index are all 0.
- Stream format: 2-byte word count N (high byte first), then N*4 image bytes. Each word is sent MSB first: byte0 -> [31:24] ... byte3 -> [7:0].
- States: CNT_HI, CNT_LO, DATA, WRITE, RUN, ERR.
- CNT_HI:
  - rx_ready = 1.
  - On accept: store N[15:8]; go to CNT_LO.
- CNT_LO:
  - rx_ready = 1.
  - On accept: form N.
  - N = 0 -> RUN.
  - N > MAX_WORDS -> ERR.
  - Otherwise -> DATA with byte index 0 and word index 0.
- DATA:
  - rx_ready = 1.
  - Each accepted byte shifts into the word register, and byte index increments mod 4.
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - imem_we = 1, imem_addr = word_index*4, imem_wdata = assembled word.
  - rx_ready = 0; any byte offered is not accepted and must be held by the sender.
  - Next: word_index+1 == N -> RUN, else word_index increments and state returns to DATA.
- Throughput: 5 cycles per word minimum (4 accept cycles + 1 write cycle).
- RUN:
  - cpu_reset = 0, done = 1, rx_ready = 0, imem_we = 0.
  - Holds until reset. cpu_reset falls in the cycle after the final WRITE pulse, so the last word is in memory before the CPU leaves reset.
- ERR:
  - error = 1, cpu_reset = 1, done = 0, rx_ready = 0, imem_we = 0.
  - Holds until reset. No memory write occurs for an erroneous count.
- imem_addr and imem_wdata hold their last written values outside WRITE.
- imem_addr never exceeds (MAX_WORDS-1)*4.
- Reset in any state, including mid-word or during WRITE:
  - All outputs return to reset values next edge and the partial word is discarded.
  - Words already written remain in instruction memory (not cleared). A WRITE cycle coinciding with reset still presents imem_we for that cycle only if reset was not sampled at the preceding edge.
- cpu_reset is a registered output, glitch-free.

Test Plan:
1. Reset, stream 00 02 | 20 08 00 05 | 01 09 50 20, rx_valid held high -> two imem_we pulses: addr 0x0 data 0x20080005, then addr 0x4 data 0x01095020. rx_ready is low during each pulse. cpu_reset falls and done rises one cycle after the 2nd pulse.
2. Stream 00 00 -> no imem_we; cpu_reset=0, done=1 the cycle after the 2nd byte is accepted; rx_ready=0 thereafter.
3. ADDR_WIDTH=8, stream 01 01 (N=257) -> ERR: error=1, cpu_reset stays 1, rx_ready=0, no writes. Subsequent bytes are ignored until reset.
4. N=1 with rx_valid toggling 1,0,0,1,0,1,1 across image bytes DE AD BE EF -> single write addr 0x0 data 0xDEADBEEF. Only valid&&ready cycles count.
5. N=3, assert reset after the 2nd byte of word 1 -> outputs return to reset values. Word 0 is not rewritten. A fresh stream 00 01 AA BB CC DD writes 0xAABBCCDD at addr 0x0.
6. N=256 full image (word i = i) -> last write at addr 0x3FC data 0x000000FF. Exactly 256 pulses. done asserted afterwards.
